color_stats_calibration: RTL and testbench

//  Multi-channel successor to single-colour mean calibration. Runs on the D5M pixel clock beside the raw Bayer stream.

---
 rtl/color_cal_pkg.sv | 30 +++
 rtl/seq_divider.sv | 76 +++++++
 rtl/color_stats_calibration.sv | 225 ++++++++++++++++++++++
 tb/tb_color_stats_calibration.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/color_cal_pkg.sv
// Shared types and constants for the per-channel Bayer colour calibration block.
package color_cal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACCUM  = 2'd2,
    DIVIDE = 2'd3
  } cal_state_e;

  localparam int NUM_CH = 4;

  localparam logic [1:0] CH_G1 = 2'd0;
  localparam logic [1:0] CH_R  = 2'd1;
  localparam logic [1:0] CH_B  = 2'd2;
  localparam logic [1:0] CH_G2 = 2'd3;

  // Bayer site of a pixel from the LSBs of its column and row.
  function automatic logic [1:0] bayer_ch(input logic x_lsb, input logic y_lsb);
    logic [1:0] ch;
    case ({y_lsb, x_lsb})
      2'b00:   ch = CH_G1;
      2'b01:   ch = CH_R;
      2'b10:   ch = CH_B;
      default: ch = CH_G2;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses NUM_W+1 cycles after start.
module seq_divider #(
  parameter int NUM_W = 36,
  parameter int DEN_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic [NUM_W-1:0] o_quot,
  output logic             o_done
);

  localparam int STEP_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0]  r_q;
  logic [DEN_W:0]    r_rem;
  logic [DEN_W-1:0]  r_den;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;
  logic              r_done;

  logic [DEN_W:0]    w_shift;
  logic [DEN_W+1:0]  w_diff;
  logic              w_take;
  logic [DEN_W:0]    w_rem_next;
  logic [NUM_W-1:0]  w_q_next;

  // A set remainder MSB means the true shifted value already exceeds any divisor.
  always_comb begin
    w_shift    = {r_rem[DEN_W-1:0], r_q[NUM_W-1]};
    w_diff     = {1'b0, w_shift} - {2'b00, r_den};
    w_take     = r_rem[DEN_W] | ~w_diff[DEN_W+1];
    w_rem_next = w_shift;
    w_q_next   = {r_q[NUM_W-2:0], 1'b0};
    if (w_take) begin
      w_rem_next = w_diff[DEN_W:0];
      w_q_next   = {r_q[NUM_W-2:0], 1'b1};
    end else begin
      w_rem_next = w_shift;
      w_q_next   = {r_q[NUM_W-2:0], 1'b0};
    end
  end

  // Iteration state; the last shift step raises done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= {NUM_W{1'b0}};
      r_rem  <= {(DEN_W+1){1'b0}};
      r_den  <= {DEN_W{1'b0}};
      r_step <= {STEP_W{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_q    <= i_num;
      r_rem  <= {(DEN_W+1){1'b0}};
      r_den  <= i_den;
      r_step <= STEP_W'(NUM_W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_q    <= w_q_next;
      r_rem  <= w_rem_next;
      r_step <= r_step - STEP_W'(1);
      r_busy <= (r_step != STEP_W'(1));
      r_done <= (r_step == STEP_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_quot = r_q;
  assign o_done = r_done;

endmodule

// File: rtl/color_stats_calibration.sv
// Per-Bayer-site ROI mean calibration over NUM_FRAMES frames on the D5M pixel clock.
// Optional per-channel min/max outputs with COLOR_STATS_MINMAX_EN.
module color_stats_calibration
  import color_cal_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int COORD_W    = 16,
  parameter int CNT_W      = 24,
  parameter int NUM_FRAMES = 4
) (
  input  logic                  D5M_PXCLK,
  input  logic                  iRST_N,
  input  logic                  iEN,
  input  logic                  iCAL_SW,
  input  logic                  iFVAL,
  input  logic                  iDATA_VAL,
  input  logic [DATA_W-1:0]     iDATA,
  input  logic [COORD_W-1:0]    iX_Cont,
  input  logic [COORD_W-1:0]    iY_Cont,
  input  logic [COORD_W-1:0]    iROI_X0,
  input  logic [COORD_W-1:0]    iROI_X1,
  input  logic [COORD_W-1:0]    iROI_Y0,
  input  logic [COORD_W-1:0]    iROI_Y1,
  output logic [4*DATA_W-1:0]   oMEAN,
  output logic                  oMEAN_VAL,
  output logic                  oBUSY,
  output logic                  oERR
`ifdef COLOR_STATS_MINMAX_EN
  ,output logic [4*DATA_W-1:0]  oMIN
  ,output logic [4*DATA_W-1:0]  oMAX
`endif
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  cal_state_e          r_state, w_next;
  logic                r_fval_d;
  logic [COORD_W-1:0]  r_x0, r_x1, r_y0, r_y1;
  logic [SUM_W-1:0]    r_sum [NUM_CH];
  logic [CNT_W-1:0]    r_cnt [NUM_CH];
  logic [FRM_W-1:0]    r_frm;
  logic [1:0]          r_ch;
  logic [3*DATA_W-1:0] r_lanes;

  logic [COORD_W-1:0]  w_x0, w_x1, w_y0, w_y1;
  logic [1:0]          w_c, w_div_ch;
  logic                w_rise, w_fall, w_abort, w_arm, w_acc, w_sat, w_last;
  logic                w_div_start, w_div_done, w_ch_done, w_publish, w_cnt_zero;
  logic [SUM_W-1:0]    w_quot;
  logic [DATA_W-1:0]   w_lane;

  assign w_rise  = iFVAL & ~r_fval_d;
  assign w_fall  = ~iFVAL & r_fval_d;
  assign w_abort = ~iEN | ~iCAL_SW;
  assign w_arm   = (r_state == IDLE) & iEN & iCAL_SW;
  // The frame-start cycle still sees the live ROI; it is latched on that same edge.
  assign w_x0    = (r_state == ARMED) ? iROI_X0 : r_x0;
  assign w_x1    = (r_state == ARMED) ? iROI_X1 : r_x1;
  assign w_y0    = (r_state == ARMED) ? iROI_Y0 : r_y0;
  assign w_y1    = (r_state == ARMED) ? iROI_Y1 : r_y1;
  assign w_c     = bayer_ch(iX_Cont[0], iY_Cont[0]);
  assign w_acc   = iFVAL & iDATA_VAL & ~w_abort
                 & (iX_Cont >= w_x0) & (iX_Cont <= w_x1)
                 & (iY_Cont >= w_y0) & (iY_Cont <= w_y1)
                 & ((r_state == ACCUM) | ((r_state == ARMED) & w_rise));
  assign w_sat   = w_acc & (r_cnt[w_c] == {CNT_W{1'b1}});
  assign w_last  = (r_state == ACCUM) & w_fall & ~w_abort
                 & (r_frm == FRM_W'(NUM_FRAMES - 1));

  assign w_ch_done   = (r_state == DIVIDE) & w_div_done & ~w_abort;
  assign w_publish   = w_ch_done & (r_ch == CH_G2);
  assign w_div_start = w_last | (w_ch_done & (r_ch != CH_G2));
  assign w_div_ch    = (r_state == DIVIDE) ? (r_ch + 2'd1) : CH_G1;
  assign w_cnt_zero  = (r_cnt[r_ch] == {CNT_W{1'b0}});

  seq_divider #(.NUM_W(SUM_W), .DEN_W(CNT_W)) u_div (
    .i_clk   (D5M_PXCLK),
    .i_rst_n (iRST_N),
    .i_start (w_div_start),
    .i_num   (r_sum[w_div_ch]),
    .i_den   (r_cnt[w_div_ch]),
    .o_quot  (w_quot),
    .o_done  (w_div_done)
  );

  // Lane value for the channel that just finished dividing.
  always_comb begin
    w_lane = w_quot[DATA_W-1:0];
    if (w_cnt_zero) begin
      w_lane = {DATA_W{1'b0}};
    end else if (|w_quot[SUM_W-1:DATA_W]) begin
      w_lane = {DATA_W{1'b1}};
    end else begin
      w_lane = w_quot[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iEN & iCAL_SW) w_next = ARMED;  else w_next = IDLE;
      ARMED:   if (w_abort)       w_next = IDLE;
               else if (w_rise)   w_next = ACCUM;  else w_next = ARMED;
      ACCUM:   if (w_abort)       w_next = IDLE;
               else if (w_last)   w_next = DIVIDE; else w_next = ACCUM;
      DIVIDE:  if (w_abort | w_publish) w_next = IDLE; else w_next = DIVIDE;
      default: w_next = IDLE;
    endcase
  end

  // State, channel sequencer, frame-valid history and ROI capture.
  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= IDLE;
      r_ch     <= CH_G1;
      r_fval_d <= 1'b0;
      r_x0     <= {COORD_W{1'b0}};
      r_x1     <= {COORD_W{1'b0}};
      r_y0     <= {COORD_W{1'b0}};
      r_y1     <= {COORD_W{1'b0}};
    end else begin
      r_state  <= w_next;
      r_fval_d <= iFVAL;
      if (w_last) begin
        r_ch <= CH_G1;
      end else if (w_ch_done & (r_ch != CH_G2)) begin
        r_ch <= r_ch + 2'd1;
      end
      if ((r_state == ARMED) & w_rise) begin
        r_x0 <= iROI_X0;
        r_x1 <= iROI_X1;
        r_y0 <= iROI_Y0;
        r_y1 <= iROI_Y1;
      end
    end
  end

  // Accumulators and frame counter.
  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_frm <= {FRM_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        r_sum[c] <= {SUM_W{1'b0}};
        r_cnt[c] <= {CNT_W{1'b0}};
      end
    end else if (w_arm) begin
      r_frm <= {FRM_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        r_sum[c] <= {SUM_W{1'b0}};
        r_cnt[c] <= {CNT_W{1'b0}};
      end
    end else begin
      if (w_acc & ~w_sat) begin
        r_sum[w_c] <= r_sum[w_c] + {{CNT_W{1'b0}}, iDATA};
        r_cnt[w_c] <= r_cnt[w_c] + CNT_W'(1);
      end
      if ((r_state == ACCUM) & w_fall & ~w_abort) begin
        r_frm <= r_frm + FRM_W'(1);
      end
    end
  end

  // Registered outputs; all four mean lanes change together on publish.
  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_lanes   <= {(3*DATA_W){1'b0}};
      oMEAN     <= {(4*DATA_W){1'b0}};
      oMEAN_VAL <= 1'b0;
      oBUSY     <= 1'b0;
      oERR      <= 1'b0;
    end else begin
      oMEAN_VAL <= w_publish;
      oBUSY     <= (w_next != IDLE);
      if (w_arm) begin
        oERR <= 1'b0;
      end else if (w_sat | (w_ch_done & w_cnt_zero)) begin
        oERR <= 1'b1;
      end
      if (w_ch_done) begin
        case (r_ch)
          CH_G1:   r_lanes[DATA_W-1:0]          <= w_lane;
          CH_R:    r_lanes[2*DATA_W-1:DATA_W]   <= w_lane;
          CH_B:    r_lanes[3*DATA_W-1:2*DATA_W] <= w_lane;
          default: oMEAN                        <= {w_lane, r_lanes};
        endcase
      end
    end
  end

`ifdef COLOR_STATS_MINMAX_EN
  logic [DATA_W-1:0] r_min [NUM_CH];
  logic [DATA_W-1:0] r_max [NUM_CH];

  // Extremes over accepted pixels, published alongside the means.
  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oMIN <= {(4*DATA_W){1'b0}};
      oMAX <= {(4*DATA_W){1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        r_min[c] <= {DATA_W{1'b1}};
        r_max[c] <= {DATA_W{1'b0}};
      end
    end else if (w_arm) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_min[c] <= {DATA_W{1'b1}};
        r_max[c] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_acc) begin
        if (iDATA < r_min[w_c]) r_min[w_c] <= iDATA;
        if (iDATA > r_max[w_c]) r_max[w_c] <= iDATA;
      end
      if (w_publish) begin
        for (int c = 0; c < NUM_CH; c++) begin
          oMIN[c*DATA_W +: DATA_W] <= (r_cnt[c] == {CNT_W{1'b0}}) ? {DATA_W{1'b0}} : r_min[c];
          oMAX[c*DATA_W +: DATA_W] <= (r_cnt[c] == {CNT_W{1'b0}}) ? {DATA_W{1'b0}} : r_max[c];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_color_stats_calibration.sv
// Scoreboard bench for color_stats_calibration (NUM_FRAMES=2, small synthetic frames).
module tb_color_stats_calibration;

  localparam int DATA_W  = 12;
  localparam int COORD_W = 16;
  localparam int CNT_W   = 24;
  localparam int NF      = 2;
  localparam int SUM_W   = DATA_W + CNT_W;
  localparam int LAT     = 4 * (SUM_W + 1) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 iEN, iCAL_SW, iFVAL, iDATA_VAL;
  logic [DATA_W-1:0]    iDATA;
  logic [COORD_W-1:0]   iX_Cont, iY_Cont, iROI_X0, iROI_X1, iROI_Y0, iROI_Y1;
  logic [4*DATA_W-1:0]  oMEAN;
  logic                 oMEAN_VAL, oBUSY, oERR;
`ifdef COLOR_STATS_MINMAX_EN
  logic [4*DATA_W-1:0]  oMIN, oMAX;
`endif

  always #5 clk = ~clk;

  color_stats_calibration #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .CNT_W(CNT_W), .NUM_FRAMES(NF)
  ) dut (
    .D5M_PXCLK(clk), .iRST_N(rst_n), .iEN(iEN), .iCAL_SW(iCAL_SW),
    .iFVAL(iFVAL), .iDATA_VAL(iDATA_VAL), .iDATA(iDATA),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iROI_X0(iROI_X0), .iROI_X1(iROI_X1), .iROI_Y0(iROI_Y0), .iROI_Y1(iROI_Y1),
    .oMEAN(oMEAN), .oMEAN_VAL(oMEAN_VAL), .oBUSY(oBUSY), .oERR(oERR)
`ifdef COLOR_STATS_MINMAX_EN
    , .oMIN(oMIN), .oMAX(oMAX)
`endif
  );

  typedef struct {
    logic [4*DATA_W-1:0] mean;
    logic                err;
    logic [4*DATA_W-1:0] mn;
    logic [4*DATA_W-1:0] mx;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fails  = 0;
  int     cyc      = 0;
  int     last_fall_cyc = 0;
  longint m_sum[4];
  int     m_cnt[4], m_min[4], m_max[4];
  int     roi_x0, roi_x1, roi_y0, roi_y1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit in_roi(input int x, input int y);
    return (x >= roi_x0) && (x <= roi_x1) && (y >= roi_y0) && (y <= roi_y1);
  endfunction

  // mode 0: constant va; 1: Bayer G=100 R=200 B=50; 2: va inside ROI, vb outside; 3: va/vb by column bit 1
  function automatic int pix(input int mode, input int x, input int y, input int va, input int vb);
    int c;
    c = (y % 2) * 2 + (x % 2);
    case (mode)
      0: return va;
      1: return (c == 1) ? 200 : ((c == 2) ? 50 : 100);
      2: return in_roi(x, y) ? va : vb;
      default: return ((x >> 1) & 1) ? vb : va;
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_sum[c] = 0; m_cnt[c] = 0; m_min[c] = 4095; m_max[c] = 0;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    int   m;
    e.err = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m = (m_cnt[c] == 0) ? 0 : int'(m_sum[c] / m_cnt[c]);
      if (m > 4095) m = 4095;
      if (m_cnt[c] == 0) e.err = 1'b1;
      e.mean[c*DATA_W +: DATA_W] = m[DATA_W-1:0];
      e.mn[c*DATA_W +: DATA_W]   = (m_cnt[c] == 0) ? 12'd0 : m_min[c][DATA_W-1:0];
      e.mx[c*DATA_W +: DATA_W]   = (m_cnt[c] == 0) ? 12'd0 : m_max[c][DATA_W-1:0];
    end
    sb.push_back(e);
  endtask

  task automatic drive_frame(input int fx0, input int fy0, input int w, input int h,
                             input int mode, input int va, input int vb);
    int v, c;
    repeat (3) begin
      @(posedge clk); #1;
      iFVAL = 1'b0; iDATA_VAL = 1'b0;
    end
    for (int y = fy0; y < fy0 + h; y++) begin
      for (int x = fx0; x < fx0 + w; x++) begin
        @(posedge clk); #1;
        v = pix(mode, x, y, va, vb);
        iFVAL = 1'b1; iDATA_VAL = 1'b1;
        iX_Cont = x[COORD_W-1:0]; iY_Cont = y[COORD_W-1:0]; iDATA = v[DATA_W-1:0];
        if (in_roi(x, y)) begin
          c = (y % 2) * 2 + (x % 2);
          m_sum[c] += v; m_cnt[c]++;
          if (v < m_min[c]) m_min[c] = v;
          if (v > m_max[c]) m_max[c] = v;
        end
      end
      @(posedge clk); #1;
      iDATA_VAL = 1'b0;
    end
    @(posedge clk); #1;
    iFVAL = 1'b0; iDATA_VAL = 1'b0;
    last_fall_cyc = cyc;
  endtask

  task automatic arm_and_drive(input int x0, input int x1, input int y0, input int y1,
                               input int fx0, input int fy0, input int w, input int h,
                               input int mode, input int va0, input int va1, input int vb);
    roi_x0 = x0; roi_x1 = x1; roi_y0 = y0; roi_y1 = y1;
    @(posedge clk); #1;
    iROI_X0 = x0[COORD_W-1:0]; iROI_X1 = x1[COORD_W-1:0];
    iROI_Y0 = y0[COORD_W-1:0]; iROI_Y1 = y1[COORD_W-1:0];
    iEN = 1'b1; iCAL_SW = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    drive_frame(fx0, fy0, w, h, mode, va0, vb);
    drive_frame(fx0, fy0, w, h, mode, va1, vb);
  endtask

  task automatic wait_val();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 50 && !seen; i++) begin
      @(negedge clk);
      if (oMEAN_VAL) seen = 1'b1;
    end
    check("mean_val_seen", 64'(seen), 64'd1);
    iCAL_SW = 1'b0;
  endtask

  task automatic run_cal(input int x0, input int x1, input int y0, input int y1,
                         input int fx0, input int fy0, input int w, input int h,
                         input int mode, input int va0, input int va1, input int vb);
    arm_and_drive(x0, x1, y0, y1, fx0, fy0, w, h, mode, va0, va1, vb);
    push_expect();
    wait_val();
  endtask

  // Scoreboard consumer: every result pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && oMEAN_VAL) begin
      if (sb.size() == 0) begin
        check("sb_depth_at_val", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("mean", 64'(oMEAN), 64'(e.mean));
        check("err", 64'(oERR), 64'(e.err));
        check("latency", 64'(cyc - last_fall_cyc), 64'(LAT));
`ifdef COLOR_STATS_MINMAX_EN
        check("min", 64'(oMIN), 64'(e.mn));
        check("max", 64'(oMAX), 64'(e.mx));
`endif
      end
    end
  end

  initial begin
    logic [4*DATA_W-1:0] mean82;
    mean82 = {4{12'd82}};
    rst_n = 1'b0; iEN = 1'b0; iCAL_SW = 1'b0; iFVAL = 1'b0; iDATA_VAL = 1'b0;
    iDATA = '0; iX_Cont = '0; iY_Cont = '0;
    iROI_X0 = '0; iROI_X1 = '0; iROI_Y0 = '0; iROI_Y1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mean", 64'(oMEAN), 64'd0);
    check("rst_val", 64'(oMEAN_VAL), 64'd0);
    check("rst_busy", 64'(oBUSY), 64'd0);
    check("rst_err", 64'(oERR), 64'd0);
    rst_n = 1'b1;

    // T1: flat 82, full ROI
    run_cal(0, 639, 0, 479, 0, 0, 8, 4, 0, 82, 82, 0);

    // T5a: abort mid-accumulation keeps the previous result
    roi_x0 = 0; roi_x1 = 639; roi_y0 = 0; roi_y1 = 479;
    @(posedge clk); #1;
    iCAL_SW = 1'b1; iEN = 1'b1;
    repeat (4) @(posedge clk);
    for (int x = 0; x < 5; x++) begin
      @(posedge clk); #1;
      iFVAL = 1'b1; iDATA_VAL = 1'b1; iX_Cont = 16'(x); iY_Cont = 16'd0; iDATA = 12'd500;
    end
    @(negedge clk);
    check("abort_busy_before", 64'(oBUSY), 64'd1);
    @(posedge clk); #1;
    iCAL_SW = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_after", 64'(oBUSY), 64'd0);
    repeat (3) @(posedge clk);
    #1; iFVAL = 1'b0; iDATA_VAL = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("abort_mean_held", 64'(oMEAN), 64'(mean82));

    // T2: Bayer pattern
    run_cal(0, 639, 0, 479, 0, 0, 8, 4, 1, 0, 0, 0);
    // T3: two frames 80 then 90
    run_cal(0, 639, 0, 479, 0, 0, 8, 4, 0, 80, 90, 0);
    // T4: 2x2 ROI, 67 inside and 197 outside
    run_cal(100, 101, 10, 11, 96, 8, 8, 6, 2, 67, 67, 197);

    // T5b: reset during the divide phase
    arm_and_drive(0, 639, 0, 479, 0, 0, 8, 4, 0, 82, 82, 0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("div_busy", 64'(oBUSY), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; iCAL_SW = 1'b0;
    @(negedge clk);
    check("rst_div_mean", 64'(oMEAN), 64'd0);
    check("rst_div_val", 64'(oMEAN_VAL), 64'd0);
    check("rst_div_busy", 64'(oBUSY), 64'd0);
    check("rst_div_err", 64'(oERR), 64'd0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    // T6: inverted ROI accepts nothing
    run_cal(10, 5, 0, 479, 0, 0, 8, 4, 0, 82, 82, 0);
    // T6b: mixed 67/197 pixels (min/max checked when enabled)
    run_cal(0, 639, 0, 479, 0, 0, 8, 4, 3, 67, 67, 197);

    repeat (10) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
